// File: rtl/trig_pacer_pkg.sv
// rtl/trig_pacer_pkg.sv - shared defaults and GAP legality bounds for the trigger event pacer
package trig_pacer_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;
    localparam int GAP_DEF   = 1;
    localparam int GAP_MIN   = 1;
    localparam int GAP_MAX   = 15;
    // Gap timer is sized to hold GAP_MAX - 1, the largest reload value.
    localparam int GAP_TMR_W = 4;

endpackage

// File: rtl/trig_pacer_lane.sv
// rtl/trig_pacer_lane.sv - one lane: pending-event counter, gap timer, pulse issue and sticky overflow
module trig_pacer_lane
    import trig_pacer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ev_i,
    input  logic flush_i,
    input  logic ovf_clear_i,
    output logic trig_o,
    output logic pend_o,
    output logic ovf_o
);

    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [GAP_TMR_W-1:0] GAP_RELOAD = GAP_TMR_W'(GAP - 1);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [GAP_TMR_W-1:0] gap_q, gap_d;
    logic                 trig_q, pend_q, ovf_q, ovf_d;
    logic                 fire, sat;

    always_comb begin
        fire    = !trig_q && (gap_q == '0) && ((count_q != '0) || ev_i);
        sat     = (count_q == CNT_MAX) && ev_i && !fire;
        count_d = count_q;
        if (ev_i && !fire && !sat) begin
            count_d = count_q + CNT_W'(1);
        end else if (!ev_i && fire) begin
            count_d = count_q - CNT_W'(1);
        end
        // The high cycle itself blocks refire, so the timer covers the remaining GAP-1 low cycles.
        gap_d = gap_q;
        if (trig_q) begin
            gap_d = GAP_RELOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_TMR_W'(1);
        end
        ovf_d = ovf_q;
        if (sat) begin
            ovf_d = 1'b1;
        end else if (ovf_clear_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            gap_q   <= '0;
            trig_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            // Events this cycle are dropped, so only the clear can touch overflow.
            count_q <= '0;
            gap_q   <= '0;
            trig_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= ovf_clear_i ? 1'b0 : ovf_q;
        end else begin
            count_q <= count_d;
            gap_q   <= gap_d;
            trig_q  <= fire;
            pend_q  <= (count_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    assign trig_o = trig_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/trig_event_pacer.sv
// rtl/trig_event_pacer.sv - paces event strobes into distinct Trigger Out pulses, one independent lane per bit
module trig_event_pacer
    import trig_pacer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             ep_clk,
    input  logic             ep_reset,
    input  logic [WIDTH-1:0] ev_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] ovf_clear,
    output logic [WIDTH-1:0] ep_trigger,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow
);

    if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
        $error("trig_event_pacer: GAP must be within 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("trig_event_pacer: CNT_W must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        trig_pacer_lane #(
            .CNT_W (CNT_W),
            .GAP   (GAP)
        ) u_lane (
            .clk_i       (ep_clk),
            .rst_i       (ep_reset),
            .ev_i        (ev_in[i]),
            .flush_i     (flush),
            .ovf_clear_i (ovf_clear[i]),
            .trig_o      (ep_trigger[i]),
            .pend_o      (pending[i]),
            .ovf_o       (overflow[i])
        );
    end

endmodule

// File: tb/tb_trig_event_pacer.sv
// tb/tb_trig_event_pacer.sv - self-checking bench for trig_event_pacer
module tb_trig_event_pacer;

    localparam int W    = 16;
    localparam int CW   = 4;
    localparam int G    = 1;
    localparam int CMAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst, fl;
    logic [W-1:0] ev, clr, trig, pend, ovf;

    always #5 clk = ~clk;

    trig_event_pacer #(.WIDTH(W), .CNT_W(CW), .GAP(G)) dut (
        .ep_clk     (clk),
        .ep_reset   (rst),
        .ev_in      (ev),
        .flush      (fl),
        .ovf_clear  (clr),
        .ep_trigger (trig),
        .pending    (pend),
        .overflow   (ovf)
    );

    typedef struct {
        logic [W-1:0] ev;
        logic         fl;
        logic [W-1:0] clr;
        logic         rst;
        logic [W-1:0] trig;
        logic [W-1:0] pend;
        logic [W-1:0] ovf;
    } vec_t;

    vec_t tbl[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: per lane a queue depth and the earliest edge at which the next pulse may issue.
    int           m_cnt[W];
    int           m_next[W];
    int           m_lost[W];
    logic [W-1:0] m_trig = '0;
    logic [W-1:0] m_ovf  = '0;

    function automatic logic [W-1:0] m_pend();
        logic [W-1:0] p;
        for (int i = 0; i < W; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic void model_edge(logic [W-1:0] e, logic f, logic [W-1:0] c, logic r);
        for (int i = 0; i < W; i++) begin
            int  n;
            bit  fire;
            if (r) begin
                m_cnt[i] = 0; m_next[i] = 0; m_trig[i] = 1'b0; m_ovf[i] = 1'b0;
            end else if (f) begin
                m_cnt[i] = 0; m_next[i] = 0; m_trig[i] = 1'b0;
                if (c[i]) m_ovf[i] = 1'b0;
            end else begin
                fire = (cyc >= m_next[i]) && (m_cnt[i] > 0 || e[i]);
                if (fire) m_next[i] = cyc + G + 1;
                n = m_cnt[i] + (e[i] ? 1 : 0) - (fire ? 1 : 0);
                if (n > CMAX) begin
                    m_cnt[i] = CMAX;
                    m_ovf[i] = 1'b1;
                    m_lost[i]++;
                end else begin
                    m_cnt[i] = n;
                    if (c[i]) m_ovf[i] = 1'b0;
                end
                m_trig[i] = fire;
            end
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] e, input logic f, input logic [W-1:0] c, input logic r);
        ev = e; fl = f; clr = c; rst = r;
        @(posedge clk);
        model_edge(e, f, c, r);
        cyc++;
        #1;
        check("model_trig", trig, m_trig);
        check("model_pend", pend, m_pend());
        check("model_ovf", ovf, m_ovf);
    endtask

    task automatic add_vec(input logic [W-1:0] e, input logic [W-1:0] t,
                           input logic [W-1:0] p, input logic [W-1:0] o);
        vec_t v;
        v.ev = e; v.fl = 1'b0; v.clr = '0; v.rst = 1'b0;
        v.trig = t; v.pend = p; v.ovf = o;
        tbl.push_back(v);
    endtask

    int pulses0;
    logic [W-1:0] seen;

    initial begin
        ev = '0; fl = 1'b0; clr = '0; rst = 1'b1;
        step('0, 1'b0, '0, 1'b1);
        step(16'hFFFF, 1'b0, '0, 1'b1);
        check("reset_trig", trig, '0);
        check("reset_pend", pend, '0);
        check("reset_ovf", ovf, '0);

        // Single strobe on lane 0.
        add_vec(16'h0001, 16'h0001, 16'h0000, '0);
        add_vec(16'h0000, 16'h0000, 16'h0000, '0);
        add_vec(16'h0000, 16'h0000, 16'h0000, '0);
        // Five-cycle burst on lane 3.
        add_vec(16'h0008, 16'h0008, 16'h0000, '0);
        add_vec(16'h0008, 16'h0000, 16'h0008, '0);
        add_vec(16'h0008, 16'h0008, 16'h0008, '0);
        add_vec(16'h0008, 16'h0000, 16'h0008, '0);
        add_vec(16'h0008, 16'h0008, 16'h0008, '0);
        add_vec(16'h0000, 16'h0000, 16'h0008, '0);
        add_vec(16'h0000, 16'h0008, 16'h0008, '0);
        add_vec(16'h0000, 16'h0000, 16'h0008, '0);
        add_vec(16'h0000, 16'h0008, 16'h0000, '0);
        add_vec(16'h0000, 16'h0000, 16'h0000, '0);
        // Two lanes back to back.
        add_vec(16'h8001, 16'h8001, 16'h0000, '0);
        add_vec(16'h8001, 16'h0000, 16'h8001, '0);
        add_vec(16'h0000, 16'h8001, 16'h0000, '0);
        add_vec(16'h0000, 16'h0000, 16'h0000, '0);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].ev, tbl[k].fl, tbl[k].clr, tbl[k].rst);
            check($sformatf("vec%0d_trig", k), trig, tbl[k].trig);
            check($sformatf("vec%0d_pend", k), pend, tbl[k].pend);
            check($sformatf("vec%0d_ovf", k), ovf, tbl[k].ovf);
        end

        // Saturation on lane 0: every accepted event must eventually pulse.
        pulses0 = 0;
        m_lost[0] = 0;
        for (int k = 0; k < 40; k++) begin
            step(16'h0001, 1'b0, '0, 1'b0);
            pulses0 += int'(trig[0]);
        end
        check("sat_ovf0", ovf & 16'h0001, 16'h0001);
        for (int k = 0; k < 34; k++) begin
            step('0, 1'b0, '0, 1'b0);
            pulses0 += int'(trig[0]);
        end
        check("sat_pulses", W'(pulses0), W'(40 - m_lost[0]));
        check("sat_drained", pend & 16'h0001, 16'h0000);
        step('0, 1'b0, 16'h0001, 1'b0);
        check("ovf_clear", ovf & 16'h0001, 16'h0000);

        // Saturating event coincides with the clear: set wins.
        for (int k = 0; k < 39; k++) step(16'h0001, 1'b0, '0, 1'b0);
        step(16'h0001, 1'b0, 16'h0001, 1'b0);
        check("collide_ovf0", ovf & 16'h0001, 16'h0001);

        // Flush lane 7 in the low cycle after a pulse.
        for (int k = 0; k < 6; k++) step(16'h0080, 1'b0, '0, 1'b0);
        step(16'h0080, 1'b1, '0, 1'b0);
        check("flush_trig7", trig & 16'h0080, 16'h0000);
        check("flush_pend7", pend & 16'h0080, 16'h0000);
        check("flush_ovf0", ovf & 16'h0001, 16'h0001);
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            step('0, 1'b0, '0, 1'b0);
            seen |= trig;
        end
        check("flush_quiet", seen, '0);
        step('0, 1'b0, 16'h0001, 1'b0);

        // Reset during a lane-2 pulse.
        step(16'h0004, 1'b0, '0, 1'b0);
        step(16'h0004, 1'b0, '0, 1'b0);
        step(16'h0004, 1'b0, '0, 1'b0);
        check("pre_rst_trig2", trig & 16'h0004, 16'h0004);
        step(16'h0004, 1'b0, '0, 1'b1);
        check("rst_trig", trig, '0);
        check("rst_pend", pend, '0);
        check("rst_ovf", ovf, '0);
        step(16'h0004, 1'b0, '0, 1'b0);
        check("post_rst_trig", trig, 16'h0004);

        // Random traffic: sparse phase, then dense phase that saturates lanes.
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] e, c;
            logic         f, r;
            if (k < 200) e = W'($urandom & $urandom & $urandom);
            else         e = W'($urandom | $urandom);
            c = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            f = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 79) == 0);
            step(e, f, c, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
